// File: rtl/lsu_byte_lane_ctrl.sv
// Load/store byte-lane controller: one outstanding access, per-lane byte enables,
// handshaked memory bus with timeout, and sign/zero-extended load return.
module lsu_byte_lane_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_W-1:0]     resp_badaddr,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);
  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               wr_reg;
  logic [1:0]         size_reg;
  logic               uns_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [OFS_W-1:0]   low_lane_reg;

  logic [3:0]         size_bytes;
  logic [OFS_W-1:0]   ofs;
  logic [OFS_W-1:0]   low_lane;
  logic               illegal;
  logic [4:0]         lo5;
  logic [4:0]         hi5;
  logic [NB-1:0]      lane_mask;
  logic [DATA_W-1:0]  wdata_rep;

  always_comb begin
    size_bytes = 4'd1 << req_size;
    ofs        = req_addr[OFS_W-1:0];
    // BE slots count down from the top lane; modulo-NB arithmetic gives NB-S-k directly
    low_lane   = (BIG_ENDIAN != 0) ? (OFS_W'(0) - OFS_W'(size_bytes) - ofs) : ofs;
    illegal    = ((req_size == 2'd3) && (DATA_W == 32)) ||
                 ((req_addr[2:0] & 3'(size_bytes - 4'd1)) != 3'd0);
    lo5        = 5'(low_lane);
    hi5        = lo5 + 5'(size_bytes);
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_byte;
    always_comb begin
      case (req_size)
        2'd0:    lane_byte = req_wdata[7:0];
        2'd1:    lane_byte = req_wdata[8*(gi%2) +: 8];
        2'd2:    lane_byte = req_wdata[8*(gi%4) +: 8];
        default: lane_byte = req_wdata[8*(gi%8) +: 8];
      endcase
    end
    assign wdata_rep[8*gi +: 8] = lane_byte;
    assign lane_mask[gi]        = (5'(gi) >= lo5) && (5'(gi) < hi5);
  end

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] load_ext;
  logic              sign;

  // The access always occupies a contiguous lane run starting at low_lane_reg,
  // with the most significant byte in the highest lane for both endiannesses.
  always_comb begin
    shifted = mem_rdata >> {low_lane_reg, 3'b000};
    case (size_reg)
      2'd0:    begin keep = DATA_W'(8'hFF);         sign = shifted[7];        end
      2'd1:    begin keep = DATA_W'(16'hFFFF);      sign = shifted[15];       end
      2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); sign = shifted[31];       end
      default: begin keep = '1;                     sign = shifted[DATA_W-1]; end
    endcase
    load_ext = (shifted & keep) | ((sign && !uns_reg) ? ~keep : '0);
  end

  logic timed_out;
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_reg       <= 1'b0;
      size_reg     <= 2'd0;
      uns_reg      <= 1'b0;
      addr_reg     <= '0;
      low_lane_reg <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 2'd0;
      resp_badaddr <= '0;
      mem_en       <= 1'b0;
      mem_wen      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready    <= 1'b0;
            wr_reg       <= req_wr;
            size_reg     <= req_size;
            uns_reg      <= req_unsigned;
            addr_reg     <= req_addr;
            low_lane_reg <= low_lane;
            if (illegal) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_err     <= 2'd1;
              resp_badaddr <= req_addr;
            end else begin
              state     <= BUS;
              cnt       <= '0;
              mem_en    <= 1'b1;
              mem_wen   <= req_wr ? lane_mask : '0;
              mem_addr  <= {req_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
              mem_wdata <= wdata_rep;
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            state      <= RESP;
            mem_en     <= 1'b0;
            mem_wen    <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= wr_reg ? '0 : load_ext;
          end else if (timed_out) begin
            state        <= RESP;
            mem_en       <= 1'b0;
            mem_wen      <= '0;
            resp_valid   <= 1'b1;
            resp_err     <= 2'd2;
            resp_badaddr <= addr_reg;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          resp_valid   <= 1'b0;
          resp_rdata   <= '0;
          resp_err     <= 2'd0;
          resp_badaddr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_byte_lane_ctrl.sv
// Bench for lsu_byte_lane_ctrl: a 32-bit big-endian and a 64-bit little-endian
// instance, directed vector table, random traffic against a byte-address model.
module tb_lsu_byte_lane_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_wr = 1'b0, req_unsigned = 1'b0, mem_ack = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, mem_rdata = '0;

  logic        req_ready_a, resp_valid_a, mem_en_a;
  logic [31:0] resp_rdata_a, resp_badaddr_a, mem_addr_a, mem_wdata_a;
  logic [1:0]  resp_err_a;
  logic [3:0]  mem_wen_a;
  logic        req_ready_b, resp_valid_b, mem_en_b;
  logic [63:0] resp_rdata_b, mem_wdata_b;
  logic [31:0] resp_badaddr_b, mem_addr_b;
  logic [1:0]  resp_err_b;
  logic [7:0]  mem_wen_b;

  always #5 clk = ~clk;

  lsu_byte_lane_ctrl #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT(TMO)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a), .resp_badaddr(resp_badaddr_a),
    .mem_en(mem_en_a), .mem_wen(mem_wen_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata[31:0]), .mem_ack(mem_ack));

  lsu_byte_lane_ctrl #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT(TMO)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .resp_badaddr(resp_badaddr_b),
    .mem_en(mem_en_b), .mem_wen(mem_wen_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  // Observation mux: sel picks the instance under test, A is zero-extended to 64 bits
  logic        sel = 1'b0;
  logic        o_ready, o_valid, o_en;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_bad, o_maddr;
  logic [1:0]  o_err;
  logic [7:0]  o_wen;
  always_comb begin
    if (sel) begin
      o_ready = req_ready_b; o_valid = resp_valid_b; o_en = mem_en_b;
      o_rdata = resp_rdata_b; o_wdata = mem_wdata_b; o_bad = resp_badaddr_b;
      o_maddr = mem_addr_b; o_err = resp_err_b; o_wen = mem_wen_b;
    end else begin
      o_ready = req_ready_a; o_valid = resp_valid_a; o_en = mem_en_a;
      o_rdata = {32'h0, resp_rdata_a}; o_wdata = {32'h0, mem_wdata_a}; o_bad = resp_badaddr_a;
      o_maddr = mem_addr_a; o_err = resp_err_a; o_wen = {4'h0, mem_wen_a};
    end
  end

  typedef struct {
    logic        sel;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          dly;       // BUS cycles before mem_ack; >= TMO means never
    logic [7:0]  exp_wen;
    logic [31:0] exp_maddr;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_err;
    logic [31:0] exp_bad;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: memory byte at addr+i sits in lane k+i (LE) or NB-1-(k+i) (BE);
  // BE values are assembled with the lowest address as the most significant byte.
  function automatic vec_t model(input vec_t v);
    int nb, s, k, lane, sh;
    logic [63:0] val;
    nb = v.sel ? 8 : 4;
    s  = 1 << v.size;
    k  = int'(v.addr % nb);
    v.exp_wen = '0; v.exp_wdata = '0; v.exp_rdata = '0;
    v.exp_maddr = v.addr - k; v.exp_err = 2'd0; v.exp_bad = '0;
    if ((v.size == 2'd3 && nb == 4) || (v.addr % s) != 0) begin
      v.exp_err = 2'd1; v.exp_bad = v.addr; v.exp_lat = 1; v.exp_en = 0;
      return v;
    end
    for (int l = 0; l < nb; l++) v.exp_wdata[8*l +: 8] = v.wdata[8*(l % s) +: 8];
    val = '0;
    for (int i = 0; i < s; i++) begin
      lane = v.sel ? (k + i) : (nb - 1 - (k + i));
      sh   = v.sel ? 8*i : 8*(s - 1 - i);
      if (v.wr) v.exp_wen[lane] = 1'b1;
      val = val | (64'(v.rdata[8*lane +: 8]) << sh);
    end
    if (!v.uns && val[8*s-1]) val = val | (~64'h0 << (8*s));
    if (nb == 4) val = val & 64'hFFFF_FFFF;
    if (v.dly >= TMO) begin
      v.exp_err = 2'd2; v.exp_bad = v.addr; v.exp_rdata = '0;
      v.exp_lat = TMO + 1; v.exp_en = TMO;
    end else begin
      v.exp_rdata = v.wr ? 64'h0 : val;
      v.exp_lat = v.dly + 2; v.exp_en = v.dly + 1;
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int  cyc, en_cnt;
    bit  got;
    @(negedge clk);
    sel = v.sel; req_wr = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.rdata; mem_ack = 1'b0;
    if (v.sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    #1 chk("req_ready_idle", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1 req_valid_a = 1'b0; req_valid_b = 1'b0;
    cyc = 0; en_cnt = 0; got = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (o_valid) begin
        got = 1'b1;
        mem_ack = 1'b0;
        chk("latency", 64'(cyc), 64'(v.exp_lat));
        chk("resp_rdata", o_rdata, v.exp_rdata);
        chk("resp_err", 64'(o_err), 64'(v.exp_err));
        chk("resp_badaddr", 64'(o_bad), 64'(v.exp_bad));
        chk("mem_en_at_resp", 64'(o_en), 64'd0);
        chk("req_ready_busy", 64'(o_ready), 64'd0);
      end else if (o_en) begin
        en_cnt++;
        chk("mem_wen", 64'(o_wen), 64'(v.exp_wen));
        chk("mem_addr", 64'(o_maddr), 64'(v.exp_maddr));
        chk("mem_wdata", o_wdata, v.exp_wdata);
        mem_ack = (v.dly == cyc - 1);
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    chk("resp_seen", 64'(got), 64'd1);
    chk("mem_en_cycles", 64'(en_cnt), 64'(v.exp_en));
    $display("txn dut=%0d wr=%0d size=%0d uns=%0d addr=%08h -> err=%0d rdata=%016h lat=%0d",
             v.sel, v.wr, v.size, v.uns, v.addr, o_err, o_rdata, cyc);
  endtask

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          sel wr sz un addr        wdata        rdata                  dly wen    maddr        exp_wdata               exp_rdata              err bad       lat en
    tbl[0] = '{0, 1, 0, 0, 32'h1003, 64'hA5,       64'h0,                 0,  8'h01, 32'h1000, 64'hA5A5A5A5,          64'h0,                 0, 32'h0,    2, 1};
    tbl[1] = '{0, 0, 1, 0, 32'h2002, 64'h0,        64'h12348001,          0,  8'h00, 32'h2000, 64'h0,                 64'hFFFF8001,          0, 32'h0,    2, 1};
    tbl[2] = '{0, 0, 1, 1, 32'h2002, 64'h0,        64'h12348001,          0,  8'h00, 32'h2000, 64'h0,                 64'h00008001,          0, 32'h0,    2, 1};
    tbl[3] = '{1, 0, 2, 0, 32'h4004, 64'h0,        64'h8765432100000000,  0,  8'h00, 32'h4000, 64'h0,                 64'hFFFFFFFF87654321,  0, 32'h0,    2, 1};
    tbl[4] = '{0, 1, 2, 0, 32'h3002, 64'h11223344, 64'h0,                 0,  8'h00, 32'h0,    64'h0,                 64'h0,                 1, 32'h3002, 1, 0};
    tbl[5] = '{0, 0, 3, 0, 32'h4000, 64'h0,        64'h0,                 0,  8'h00, 32'h0,    64'h0,                 64'h0,                 1, 32'h4000, 1, 0};
    tbl[6] = '{0, 0, 2, 0, 32'h5000, 64'h0,        64'hCAFEF00D,          99, 8'h00, 32'h5000, 64'h0,                 64'h0,                 2, 32'h5000, 5, 4};
    tbl[7] = '{0, 1, 2, 0, 32'h6000, 64'hDEADBEEF, 64'h0,                 1,  8'h0F, 32'h6000, 64'hDEADBEEF,          64'h0,                 0, 32'h0,    3, 2};
    tbl[8] = '{1, 1, 0, 0, 32'h7005, 64'h5A,       64'h0,                 0,  8'h20, 32'h7000, 64'h5A5A5A5A5A5A5A5A,  64'h0,                 0, 32'h0,    2, 1};
    tbl[9] = '{0, 1, 1, 0, 32'h1002, 64'hBEEF,     64'h0,                 2,  8'h03, 32'h1000, 64'hBEEFBEEF,          64'h0,                 0, 32'h0,    4, 3};

    // Reset state on both instances
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk("rst_req_ready", 64'(o_ready), 64'd1);
      chk("rst_resp_valid", 64'(o_valid), 64'd0);
      chk("rst_mem_en", 64'(o_en), 64'd0);
      chk("rst_mem_wen", 64'(o_wen), 64'd0);
      chk("rst_mem_addr", 64'(o_maddr), 64'd0);
      chk("rst_mem_wdata", o_wdata, 64'd0);
      chk("rst_resp_rdata", o_rdata, 64'd0);
      chk("rst_resp_err_bad", {30'h0, o_err, o_bad}, 64'd0);
    end
    #2 rst = 1'b0;

    // Stray mem_ack while idle must not produce anything
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      sel = 1'b0; #1 chk("idle_ack_a", {62'h0, o_valid, o_en}, 64'd0);
      sel = 1'b1; #1 chk("idle_ack_b", {62'h0, o_valid, o_en}, 64'd0);
    end
    mem_ack = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Asynchronous reset in the middle of a BUS cycle
    @(negedge clk);
    sel = 1'b0; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h8000; req_valid_a = 1'b1;
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    #1 chk("rstmid_en_before", 64'(o_en), 64'd1);
    rst = 1'b1;
    #1 chk("rstmid_en_drop", 64'(o_en), 64'd0);
    chk("rstmid_ready", 64'(o_ready), 64'd1);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_resp", {62'h0, o_valid, o_en}, 64'd0);
      chk("rstmid_ready_after", 64'(o_ready), 64'd1);
    end

    // Random traffic against the byte-address model
    for (int n = 0; n < 200; n++) begin
      v.sel   = 1'($urandom_range(0, 1));
      v.wr    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
      v.wdata = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.dly   = $urandom_range(0, 5);
      v = model(v);
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
